// File: rtl/l2_tcdm_bank_arbiter.sv
// ---------------------------------------------------------------------------
// l2_tcdm_bank_arbiter
//
// Purpose:
//   Shares one single-ported L2 SRAM bank between N_REQ TCDM requesters
//   (AXI-to-TCDM bridge ports, uDMA TCDM channels) using round-robin
//   arbitration, and routes the 1-cycle-latency bank response back to the
//   requester that was granted.
//
// Handshake:
//   A requester raises req_i with stable add/wen/wdata/be and holds them
//   until it sees gnt_o in the same cycle. gnt_o is combinational from req_i
//   and mem_gnt_i. Exactly one cycle after a grant, r_valid_o pulses for that
//   requester (reads and writes alike) and r_rdata_o carries the bank data.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/add_i/wen_i/
//   wdata_i/be_i           per-requester TCDM request fields (wen: 1 = read)
//   gnt_o                  per-requester grant (one-hot or zero)
//   r_valid_o, r_rdata_o   per-requester response valid, shared read data
//   mem_*_o                request towards the bank (winner's fields)
//   mem_gnt_i, mem_rdata_i bank accept and read data (1 cycle after accept)
//   clr_cnt_i              synchronous clear of the performance counters
//   grant_cnt_o            per-requester saturating grant counters
//   conflict_cnt_o         saturating count of cycles with >= 2 requests
//                          while the bank accepts
//
// Configuration:
//   L2_ARB_PERF_CNT_EN     when defined, the performance counters are built;
//                          otherwise the counter outputs are constant 0 and
//                          clr_cnt_i is ignored.
// ---------------------------------------------------------------------------
module l2_tcdm_bank_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_REQ-1:0]                     req_i,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     add_i,
    input  logic [N_REQ-1:0]                     wen_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
    input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]   be_i,
    output logic [N_REQ-1:0]                     gnt_o,
    output logic [N_REQ-1:0]                     r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 mem_req_o,
    output logic [ADDR_WIDTH-1:0]                mem_add_o,
    output logic                                 mem_wen_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]              mem_be_o,
    input  logic                                 mem_gnt_i,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
    input  logic                                 clr_cnt_i,
    output logic [N_REQ-1:0][CNT_WIDTH-1:0]      grant_cnt_o,
    output logic [CNT_WIDTH-1:0]                 conflict_cnt_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] rr_q, rr_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             any_req;
    logic             accept;

    // Requests are ignored while in reset so every output reads 0 then.
    assign any_req = rst_ni & (|req_i);
    assign accept  = any_req & mem_gnt_i;

    // Round-robin pick in two passes: first the lowest requesting index at
    // or above rr_q, otherwise the lowest requesting index overall (which
    // then lies below rr_q, i.e. the wrap-around part of the scan).
    always_comb begin : winner_sel
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_i[j] && (IDX_W'(j) >= rr_q)) begin
                winner = IDX_W'(j);
                found  = 1'b1;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_i[j]) begin
                winner = IDX_W'(j);
                found  = 1'b1;
            end
        end
    end

    // Bank-side request mux and requester-side grant.
    always_comb begin : req_path
        gnt_o       = '0;
        mem_req_o   = any_req;
        mem_add_o   = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (any_req) begin
            mem_add_o   = add_i[winner];
            mem_wen_o   = wen_i[winner];
            mem_wdata_o = wdata_i[winner];
            mem_be_o    = be_i[winner];
        end
        if (accept) begin
            gnt_o[winner] = 1'b1;
        end
    end

    // Pointer and response bookkeeping.
    always_comb begin : next_state
        rr_d      = rr_q;
        rsp_vld_d = accept;
        rsp_id_d  = rsp_id_q;
        if (accept) begin
            rsp_id_d = winner;
            rr_d     = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : state_regs
        if (!rst_ni) begin
            rr_q      <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            rr_q      <= rr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    // Response routing; read data passes straight through from the bank.
    always_comb begin : rsp_path
        r_valid_o = '0;
        if (rsp_vld_q) begin
            r_valid_o[rsp_id_q] = 1'b1;
        end
    end

    assign r_rdata_o = rst_ni ? mem_rdata_i : '0;

`ifdef L2_ARB_PERF_CNT_EN
    logic [N_REQ-1:0][CNT_WIDTH-1:0] grant_cnt_q, grant_cnt_d;
    logic [CNT_WIDTH-1:0]            conflict_cnt_q, conflict_cnt_d;
    logic                            multi_req;

    // x & (x-1) clears the lowest set bit; anything left means >= 2 requests.
    assign multi_req = |(req_i & (req_i - N_REQ'(1)));

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin : cnt_next
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (clr_cnt_i) begin
            grant_cnt_d    = '0;
            conflict_cnt_d = '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_o[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
                end
            end
            if (multi_req && mem_gnt_i && (conflict_cnt_q != '1)) begin
                conflict_cnt_d = conflict_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : cnt_regs
        if (!rst_ni) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt_o    = grant_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt_i;
    assign grant_cnt_o    = '0;
    assign conflict_cnt_o = '0;
`endif

endmodule
